// File: rtl/obi_sram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | obi_sram_responder: word-addressed SRAM behind an OBI req/gnt/rvalid port |
// | with fixed read latency and a bounded number of outstanding transfers.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module obi_sram_responder #(
  parameter int unsigned MEM_WORDS       = 8192,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter string       INIT_FILE       = ""
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  logic [31:0]   mem_q [MEM_WORDS];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q [READ_LATENCY];
  logic [31:0]   dat_q [READ_LATENCY];
  logic          err_q [READ_LATENCY];

  logic          xfer;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];

  assign in_range = {2'b00, addr_i[31:2]} < MEM_LIMIT;
  assign idx      = addr_i[AW+1:2];
  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign gnt_o    = req_i && !stall_i && ((cnt_q < MAX_CNT) || rvalid_o);
  assign xfer     = req_i && gnt_o;
  assign rd_word  = (!we_i && in_range) ? mem_q[idx] : 32'h0;

  assign rvalid_o = vld_q[READ_LATENCY-1];
  assign rdata_o  = dat_q[READ_LATENCY-1];
  assign err_o    = err_q[READ_LATENCY-1];

  // Array has no reset so contents survive a mid-operation reset.
  always_ff @(posedge clk_i) begin
    if (xfer && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (xfer && !rvalid_o)      cnt_d = cnt_q + 1'b1;
    else if (!xfer && rvalid_o) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= 32'h0;
        err_q[i] <= 1'b0;
      end
    end else begin
      cnt_q    <= cnt_d;
      vld_q[0] <= xfer;
      dat_q[0] <= xfer ? rd_word : 32'h0;
      err_q[0] <= xfer && !in_range;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
        err_q[i] <= err_q[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_sram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_obi_sram_responder: directed bench over four latency/outstanding mixes |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_obi_sram_responder;

  logic        clk;
  logic        rst_n;
  logic        req    [4];
  logic        gnt    [4];
  logic [31:0] addr   [4];
  logic        we     [4];
  logic [3:0]  be     [4];
  logic [31:0] wdata  [4];
  logic        stall  [4];
  logic        rvalid [4];
  logic [31:0] rdata  [4];
  logic        err    [4];

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // d0: L=1 M=2, d1: L=3 M=1, d2: L=2 M=2, d3: L=3 M=3
  obi_sram_responder #(.MEM_WORDS(8192), .READ_LATENCY(1), .MAX_OUTSTANDING(2)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .stall_i(stall[0]),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));
  obi_sram_responder #(.MEM_WORDS(8192), .READ_LATENCY(3), .MAX_OUTSTANDING(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .stall_i(stall[1]),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));
  obi_sram_responder #(.MEM_WORDS(8192), .READ_LATENCY(2), .MAX_OUTSTANDING(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
    .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .stall_i(stall[2]),
    .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));
  obi_sram_responder #(.MEM_WORDS(8192), .READ_LATENCY(3), .MAX_OUTSTANDING(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[3]), .gnt_o(gnt[3]), .addr_i(addr[3]),
    .we_i(we[3]), .be_i(be[3]), .wdata_i(wdata[3]), .stall_i(stall[3]),
    .rvalid_o(rvalid[3]), .rdata_o(rdata[3]), .err_o(err[3]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd);
    req[d]   = r;
    we[d]    = w;
    addr[d]  = a;
    be[d]    = b;
    wdata[d] = wd;
  endtask

  // Single transfer; returns in the cycle its response is valid.
  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] wd);
    int k;
    cyc(); drive(d, 1'b1, w, a, b, wd); #1;
    k = 0;
    while (!gnt[d] && k < 20) begin cyc(); #1; k++; end
    chk("xfer_gnt", 32'(gnt[d]), 32'd1);
    cyc(); drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
    k = 0;
    while (!rvalid[d] && k < 20) begin cyc(); #1; k++; end
    chk("xfer_rvalid", 32'(rvalid[d]), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  n;
    logic g, v;
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      stall[d] = 1'b0;
    end
    cyc(); cyc(); #1;
    for (int d = 0; d < 4; d++) begin
      chk("rst_rvalid", 32'(rvalid[d]), 32'd0);
      chk("rst_rdata",  rdata[d],       32'h0);
      chk("rst_err",    32'(err[d]),    32'd0);
      chk("rst_gnt",    32'(gnt[d]),    32'd0);
    end
    rst_n = 1'b1;

    // Full write then read-back, L=1
    cyc(); drive(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF); #1;
    chk("t1_wgnt", 32'(gnt[0]), 32'd1);
    chk("t1_idle_rvalid", 32'(rvalid[0]), 32'd0);
    cyc(); drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0); #1;
    chk("t1_wrvalid", 32'(rvalid[0]), 32'd1);
    chk("t1_wrdata", rdata[0], 32'h0);
    chk("t1_werr", 32'(err[0]), 32'd0);
    chk("t1_rgnt", 32'(gnt[0]), 32'd1);
    cyc(); drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
    chk("t1_rrvalid", 32'(rvalid[0]), 32'd1);
    chk("t1_rdata", rdata[0], 32'hDEADBEEF);
    cyc(); #1;
    chk("t1_after_rvalid", 32'(rvalid[0]), 32'd0);

    // Partial write with byte enables 0x5
    cyc(); drive(0, 1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344); #1;
    chk("t2_gnt0", 32'(gnt[0]), 32'd1);
    cyc(); drive(0, 1'b1, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD); #1;
    chk("t2_gnt1", 32'(gnt[0]), 32'd1);
    cyc(); drive(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0); #1;
    chk("t2_gnt2", 32'(gnt[0]), 32'd1);
    cyc(); drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
    chk("t2_rvalid", 32'(rvalid[0]), 32'd1);
    chk("t2_rdata", rdata[0], 32'h11BB33DD);

    // Out-of-range read and write alias word 0 in the low index bits
    cyc(); drive(0, 1'b1, 1'b1, 32'h0, 4'hF, 32'hCAFE0001); #1;
    cyc(); drive(0, 1'b1, 1'b0, 32'h8000, 4'h0, 32'h0); #1;
    chk("t5_rgnt", 32'(gnt[0]), 32'd1);
    cyc(); drive(0, 1'b1, 1'b1, 32'h8000, 4'hF, 32'hFFFFFFFF); #1;
    chk("t5_oor_rd_err", 32'(err[0]), 32'd1);
    chk("t5_oor_rd_data", rdata[0], 32'h0);
    cyc(); drive(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0); #1;
    chk("t5_oor_wr_err", 32'(err[0]), 32'd1);
    chk("t5_oor_wr_data", rdata[0], 32'h0);
    cyc(); drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
    chk("t5_word0", rdata[0], 32'hCAFE0001);
    chk("t5_word0_err", 32'(err[0]), 32'd0);

    // L=3, M=1: grants every third cycle with held request
    for (int i = 0; i < 3; i++) xfer(1, 1'b1, 32'(4*i), 4'hF, 32'hA0000000 + 32'(4*i));
    n = 0;
    for (int t = 0; t < 10; t++) begin
      cyc(); drive(1, n < 3, 1'b0, 32'(4*n), 4'h0, 32'h0); #1;
      g = (n < 3) && (t % 3 == 0);
      v = (t == 3) || (t == 6) || (t == 9);
      chk("t3_gnt", 32'(gnt[1]), 32'(g));
      chk("t3_rvalid", 32'(rvalid[1]), 32'(v));
      if (v) chk("t3_rdata", rdata[1], 32'hA0000000 + 32'(4*(t/3 - 1)));
      if (g) n++;
    end
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // L=2, M=2: eight back-to-back reads at full throughput
    for (int i = 0; i < 8; i++) xfer(2, 1'b1, 32'h100 + 32'(4*i), 4'hF, 32'h50000000 + 32'(i));
    for (int t = 0; t < 11; t++) begin
      cyc(); drive(2, t < 8, 1'b0, 32'h100 + 32'(4*t), 4'h0, 32'h0); #1;
      v = (t >= 2) && (t < 10);
      chk("t4_gnt", 32'(gnt[2]), 32'(t < 8));
      chk("t4_rvalid", 32'(rvalid[2]), 32'(v));
      if (v) chk("t4_rdata", rdata[2], 32'h50000000 + 32'(t - 2));
    end
    drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Stall, then reset with two reads in flight
    xfer(3, 1'b1, 32'h40, 4'hF, 32'h600DF00D);
    for (int t = 0; t < 5; t++) begin
      cyc(); stall[3] = 1'b1; drive(3, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0); #1;
      chk("t6_stall_gnt", 32'(gnt[3]), 32'd0);
    end
    cyc(); stall[3] = 1'b0; #1;
    chk("t6_gnt_a", 32'(gnt[3]), 32'd1);
    cyc(); drive(3, 1'b1, 1'b0, 32'h44, 4'h0, 32'h0); #1;
    chk("t6_gnt_b", 32'(gnt[3]), 32'd1);
    cyc(); drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #1;
    chk("t6_inflight_rvalid", 32'(rvalid[3]), 32'd0);
    chk("t6_inflight_cnt", 32'(u_dut3.cnt_q), 32'd2);
    rst_n = 1'b0; #1;
    chk("t6_rst_rvalid", 32'(rvalid[3]), 32'd0);
    chk("t6_rst_cnt", 32'(u_dut3.cnt_q), 32'd0);
    #1 rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      cyc(); #1;
      chk("t6_no_stale", 32'(rvalid[3]), 32'd0);
    end
    xfer(3, 1'b0, 32'h40, 4'h0, 32'h0);
    chk("t6_retained3", rdata[3], 32'h600DF00D);
    xfer(0, 1'b0, 32'h10, 4'h0, 32'h0);
    chk("t6_retained0", rdata[0], 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
